uart_recv: RTL

- UART receiver (8N1, LSB first) on the CLK domain; the receive-side counterpart of the byte transmitter in top.
- Consumes PHYSICAL_UART_RX and delivers received bytes to the CPU/top through a one-entry holding register with a valid/ack handshake.
- Bit timing is counter-based from the 100 MHz clock, using the same wtime convention as the transmitter.

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_recv_sync2.sv | 27 ++
 rtl/uart_recv.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state names, frame width and the default
// bit period used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;

  localparam int UART_DATA_BITS = 8;

  // 10416 clocks per bit: 9600 baud from the 100 MHz board clock.
  localparam logic [31:0] UART_WTIME_DEFAULT = 32'h28B0;

endpackage

// File: rtl/uart_recv_sync2.sv
// Two-flop synchronizer for a single asynchronous input. The reset value is a
// parameter so idle-high lines (UART) and idle-low lines (buttons) both work.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic CLK,
  input  logic RESET,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic q_reg;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      meta_reg <= RST_VAL;
      q_reg    <= RST_VAL;
    end else begin
      meta_reg <= d;
      q_reg    <= meta_reg;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/uart_recv.sv
// 8N1 UART receiver, LSB first, with a one-entry holding register and a
// valid/ack handshake toward the consumer.
module uart_recv #(
  parameter logic [31:0] wtime = uart_pkg::UART_WTIME_DEFAULT
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       UART_RX,
  output logic [7:0] DATA,
  output logic       DATA_VALID,
  input  logic       DATA_ACK,
  output logic       FRAME_ERR,
  output logic       OVERRUN
);
  import uart_pkg::*;

  localparam logic [2:0] ST_IDLE  = uart_pkg::IDLE;
  localparam logic [2:0] ST_START = uart_pkg::START;
  localparam logic [2:0] ST_DATA  = uart_pkg::DATA;
  localparam logic [2:0] ST_STOP  = uart_pkg::STOP;
  localparam logic [2:0] ST_BREAK = uart_pkg::BREAK;

  localparam logic [31:0] HALF_LAST = wtime / 32'd2 - 32'd1;
  localparam logic [31:0] BIT_LAST  = wtime - 32'd1;

  logic                      rx_s;
  logic                      rx_prev_reg;
  logic [2:0]                state_reg,  state_next;
  logic [31:0]               ct_reg,     ct_next;
  logic [3:0]                bit_reg,    bit_next;
  logic [UART_DATA_BITS-1:0] shreg_reg,  shreg_next;
  logic [7:0]                data_reg,   data_next;
  logic                      valid_reg,  valid_next;
  logic                      ferr_reg,   ferr_next;
  logic                      ovr_reg,    ovr_next;

  sync2 #(
    .RST_VAL (1'b1)
  ) u_rx_sync (
    .CLK   (CLK),
    .RESET (RESET),
    .d     (UART_RX),
    .q     (rx_s)
  );

  always_comb begin
    state_next = state_reg;
    ct_next    = ct_reg;
    bit_next   = bit_reg;
    shreg_next = shreg_reg;
    data_next  = data_reg;
    valid_next = valid_reg & ~DATA_ACK;
    ferr_next  = 1'b0;
    ovr_next   = ovr_reg;
    case (state_reg)
      ST_IDLE: begin
        if (rx_prev_reg && !rx_s) begin
          state_next = ST_START;
          ct_next    = '0;
        end
      end
      ST_START: begin
        if (ct_reg == HALF_LAST) begin
          ct_next    = '0;
          bit_next   = '0;
          state_next = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          ct_next = ct_reg + 32'd1;
        end
      end
      ST_DATA: begin
        if (ct_reg == BIT_LAST) begin
          ct_next                    = '0;
          shreg_next[bit_reg[2:0]]   = rx_s;
          bit_next                   = bit_reg + 4'd1;
          // bit_next[3] is the done flag: the eighth sample has just been taken.
          if (bit_next[3]) begin
            state_next = ST_STOP;
          end
        end else begin
          ct_next = ct_reg + 32'd1;
        end
      end
      ST_STOP: begin
        if (ct_reg == BIT_LAST) begin
          ct_next = '0;
          if (rx_s) begin
            state_next = ST_IDLE;
            if (!valid_reg || DATA_ACK) begin
              data_next  = shreg_reg;
              valid_next = 1'b1;
            end else begin
              ovr_next = 1'b1;
            end
          end else begin
            ferr_next  = 1'b1;
            shreg_next = '0;
            state_next = ST_BREAK;
          end
        end else begin
          ct_next = ct_reg + 32'd1;
        end
      end
      ST_BREAK: begin
        // Wait out a held-low line so it cannot retrigger a frame.
        if (rx_s) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      rx_prev_reg <= 1'b1;
      state_reg   <= ST_IDLE;
      ct_reg      <= '0;
      bit_reg     <= '0;
      shreg_reg   <= '0;
      data_reg    <= 8'h00;
      valid_reg   <= 1'b0;
      ferr_reg    <= 1'b0;
      ovr_reg     <= 1'b0;
    end else begin
      rx_prev_reg <= rx_s;
      state_reg   <= state_next;
      ct_reg      <= ct_next;
      bit_reg     <= bit_next;
      shreg_reg   <= shreg_next;
      data_reg    <= data_next;
      valid_reg   <= valid_next;
      ferr_reg    <= ferr_next;
      ovr_reg     <= ovr_next;
    end
  end

  assign DATA       = data_reg;
  assign DATA_VALID = valid_reg;
  assign FRAME_ERR  = ferr_reg;
  assign OVERRUN    = ovr_reg;

endmodule
